// File: rtl/sdrc_mport_arb_pkg.sv
// Shared constants and types for the multi-port SDRAM request arbiter.
package sdrc_mport_arb_pkg;

    localparam logic ARB_RR  = 1'b0;
    localparam logic ARB_FIX = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } arb_state_t;

    // Port-id width; a single port still needs one bit to carry an id.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sdrc_mport_arb_if.sv
// Core-side application bus between the arbiter (master) and sdrc_core (slave).
interface sdrc_mport_arb_if #(
    parameter int APP_AW = 26,
    parameter int DW     = 32,
    parameter int BL     = 9
);
    logic              app_req;
    logic [APP_AW-1:0] app_req_addr;
    logic [BL-1:0]     app_req_len;
    logic              app_req_wr_n;
    logic              app_req_wrap;
    logic              app_req_ack;
    logic [DW-1:0]     app_wr_data;
    logic [DW/8-1:0]   app_wr_en_n;
    logic              app_wr_next_req;
    logic              app_last_wr;
    logic              app_rd_valid;
    logic              app_last_rd;
    logic [DW-1:0]     app_rd_data;

    modport master (
        output app_req, app_req_addr, app_req_len, app_req_wr_n, app_req_wrap,
        output app_wr_data, app_wr_en_n,
        input  app_req_ack, app_wr_next_req, app_last_wr, app_rd_valid, app_last_rd, app_rd_data
    );

    modport slave (
        input  app_req, app_req_addr, app_req_len, app_req_wr_n, app_req_wrap,
        input  app_wr_data, app_wr_en_n,
        output app_req_ack, app_wr_next_req, app_last_wr, app_rd_valid, app_last_rd, app_rd_data
    );
endinterface

// File: rtl/sdrc_tag_fifo.sv
// Small FIFO of port ids recording which port owns each accepted request.
module sdrc_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [AW:0]      r_cnt;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_push_data;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (i_pop) r_rptr <= r_rptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_full  = (r_cnt == FULL_CNT);
    assign o_empty = (r_cnt == '0);
    assign o_head  = r_mem[r_rptr];
endmodule

// File: rtl/sdrc_mport_arb.sv
// N-port request arbiter in front of sdrc_core; routes data strobes back to the
// owning port in request order using per-direction tag FIFOs.
module sdrc_mport_arb
    import sdrc_mport_arb_pkg::*;
#(
    parameter int NPORT     = 4,
    parameter int APP_AW    = 26,
    parameter int DW        = 32,
    parameter int BL        = 9,
    parameter int TAG_DEPTH = 4
) (
    input  logic                   sdram_clk,
    input  logic                   sdram_resetn,
    input  logic                   cfg_arb_mode,
    input  logic [NPORT-1:0]       p_req,
    input  logic [NPORT*APP_AW-1:0] p_req_addr,
    input  logic [NPORT*BL-1:0]    p_req_len,
    input  logic [NPORT-1:0]       p_req_wr_n,
    input  logic [NPORT-1:0]       p_req_wrap,
    output logic [NPORT-1:0]       p_req_ack,
    input  logic [NPORT*DW-1:0]    p_wr_data,
    input  logic [NPORT*DW/8-1:0]  p_wr_en_n,
    output logic [NPORT-1:0]       p_wr_next_req,
    output logic [NPORT-1:0]       p_last_wr,
    output logic [NPORT-1:0]       p_rd_valid,
    output logic [NPORT-1:0]       p_last_rd,
    output logic [DW-1:0]          p_rd_data,
    sdrc_mport_arb_if.master       app,
    output logic                   arb_err
);
    localparam int IW = id_w(NPORT);

    logic [NPORT-1:0][APP_AW-1:0] w_addr;
    logic [NPORT-1:0][BL-1:0]     w_len;
    logic [NPORT-1:0][DW-1:0]     w_wdata;
    logic [NPORT-1:0][DW/8-1:0]   w_en_n;
    assign w_addr  = p_req_addr;
    assign w_len   = p_req_len;
    assign w_wdata = p_wr_data;
    assign w_en_n  = p_wr_en_n;

    arb_state_t        r_state;
    logic              r_app_req, r_wr_n, r_wrap, r_arb_err;
    logic [APP_AW-1:0] r_addr;
    logic [BL-1:0]     r_len;
    logic [IW-1:0]     r_grant, r_rr_ptr;

    logic              w_wr_full, w_wr_empty, w_rd_full, w_rd_empty;
    logic [IW-1:0]     w_wr_head, w_rd_head, w_win;
    logic [NPORT-1:0]  w_elig;
    logic              w_found, w_ack, w_wr_pop, w_rd_pop;

    // A full tag FIFO only blocks requests of its own direction.
    always_comb begin
        for (int i = 0; i < NPORT; i++)
            w_elig[i] = p_req[i] & ~(p_req_wr_n[i] ? w_rd_full : w_wr_full);
    end

    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NPORT; k++) begin
            int idx;
            idx = (cfg_arb_mode == ARB_RR) ? ((int'(r_rr_ptr) + k) % NPORT) : k;
            if (!w_found && w_elig[idx]) begin
                w_win   = IW'(idx);
                w_found = 1'b1;
            end
        end
    end

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            r_state   <= ST_IDLE;
            r_app_req <= 1'b0;
            r_addr    <= '0;
            r_len     <= '0;
            r_wr_n    <= 1'b0;
            r_wrap    <= 1'b0;
            r_grant   <= '0;
            r_rr_ptr  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_found) begin
                    r_grant   <= w_win;
                    r_addr    <= w_addr[w_win];
                    r_len     <= w_len[w_win];
                    r_wr_n    <= p_req_wr_n[w_win];
                    r_wrap    <= p_req_wrap[w_win];
                    r_app_req <= 1'b1;
                    r_state   <= ST_REQ;
                end
                ST_REQ: if (app.app_req_ack) begin
                    r_app_req <= 1'b0;
                    r_rr_ptr  <= (r_grant == IW'(NPORT-1)) ? '0 : r_grant + 1'b1;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign app.app_req      = r_app_req;
    assign app.app_req_addr = r_addr;
    assign app.app_req_len  = r_len;
    assign app.app_req_wr_n = r_wr_n;
    assign app.app_req_wrap = r_wrap;

    assign w_ack     = (r_state == ST_REQ) & app.app_req_ack;
    assign p_req_ack = w_ack ? (NPORT'(1) << r_grant) : '0;

    sdrc_tag_fifo #(.DEPTH(TAG_DEPTH), .WIDTH(IW)) u_wr_tags (
        .i_clk(sdram_clk), .i_rst_n(sdram_resetn),
        .i_push(w_ack & ~r_wr_n), .i_push_data(r_grant), .i_pop(w_wr_pop),
        .o_full(w_wr_full), .o_empty(w_wr_empty), .o_head(w_wr_head)
    );

    sdrc_tag_fifo #(.DEPTH(TAG_DEPTH), .WIDTH(IW)) u_rd_tags (
        .i_clk(sdram_clk), .i_rst_n(sdram_resetn),
        .i_push(w_ack & r_wr_n), .i_push_data(r_grant), .i_pop(w_rd_pop),
        .o_full(w_rd_full), .o_empty(w_rd_empty), .o_head(w_rd_head)
    );

    assign w_wr_pop = app.app_last_wr & ~w_wr_empty;
    assign w_rd_pop = app.app_last_rd & ~w_rd_empty;

    // Zero-latency demux of core strobes to the FIFO-head owner.
    always_comb begin
        app.app_wr_data = '0;
        app.app_wr_en_n = '1;
        p_wr_next_req   = '0;
        p_last_wr       = '0;
        p_rd_valid      = '0;
        p_last_rd       = '0;
        if (!w_wr_empty) begin
            app.app_wr_data          = w_wdata[w_wr_head];
            app.app_wr_en_n          = w_en_n[w_wr_head];
            p_wr_next_req[w_wr_head] = app.app_wr_next_req;
            p_last_wr[w_wr_head]     = app.app_last_wr;
        end
        if (!w_rd_empty) begin
            p_rd_valid[w_rd_head] = app.app_rd_valid;
            p_last_rd[w_rd_head]  = app.app_last_rd;
        end
    end

    assign p_rd_data = app.app_rd_data;

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn)
            r_arb_err <= 1'b0;
        else if (((app.app_wr_next_req | app.app_last_wr) & w_wr_empty) |
                 ((app.app_rd_valid | app.app_last_rd) & w_rd_empty))
            r_arb_err <= 1'b1;
    end

    assign arb_err = r_arb_err;
endmodule
